// File: rtl/ext_mem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ext_mem_loader: byte-stream host master for the processor external       |
// | memory port (instruction/data writes, data readback, start pulse).       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ext_mem_loader #(
    parameter int ADDR_W    = 9,
    parameter int READ_LAT  = 3,
    parameter int WR_HOLD   = 2,
    parameter int START_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] dram_in,
    output logic [15:0] addr_ext,
    output logic [15:0] data_in_ext,
    output logic [15:0] iram_in_ext,
    output logic        mem_write_data_ext,
    output logic        mem_write_ins,
    output logic [1:0]  read_en_ext,
    output logic        start,
    output logic        busy,
    output logic        err
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ADDR_HI = 4'd1,
        S_ADDR_LO = 4'd2,
        S_COUNT   = 4'd3,
        S_DATA_HI = 4'd4,
        S_DATA_LO = 4'd5,
        S_WRITE   = 4'd6,
        S_WR_HOLD = 4'd7,
        S_RD_REQ  = 4'd8,
        S_RD_WAIT = 4'd9,
        S_TX_HI   = 4'd10,
        S_TX_LO   = 4'd11,
        S_START   = 4'd12
    } state_t;

    localparam logic [1:0] c_OP_WR_INS  = 2'b00;
    localparam logic [1:0] c_OP_WR_DATA = 2'b01;
    localparam logic [1:0] c_OP_RD_DATA = 2'b10;
    localparam logic [1:0] c_OP_START   = 2'b11;

    localparam logic [7:0] c_HOLD_LAST  = 8'(WR_HOLD - 1);
    localparam logic [7:0] c_RD_LAST    = 8'(READ_LAT - 1);
    localparam logic [7:0] c_START_LAST = 8'(START_LEN - 1);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [7:0]          r_addr_hi, w_addr_hi_nxt;
    logic [8:0]          r_count, w_count_nxt;
    logic [1:0]          r_op, w_op_nxt;
    logic [7:0]          r_data_hi, w_data_hi_nxt;
    logic [15:0]         r_word, w_word_nxt;
    logic [7:0]          r_timer, w_timer_nxt;
    logic                r_armed;
    logic                w_fire;
    logic                w_advance;

    // Holding rx_ready low for the first cycle out of reset keeps every output at 0 during reset.
    assign rx_ready = r_armed && (r_state inside {S_IDLE, S_ADDR_HI, S_ADDR_LO,
                                                  S_COUNT, S_DATA_HI, S_DATA_LO});
    assign w_fire      = rx_valid && rx_ready;
    assign busy        = (r_state != S_IDLE);
    assign addr_ext    = 16'(r_addr);
    assign data_in_ext = (r_op == c_OP_WR_DATA) ? r_word : 16'h0000;
    assign iram_in_ext = (r_op == c_OP_WR_INS)  ? r_word : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_addr_hi <= 8'h00;
            r_count   <= 9'd0;
            r_op      <= 2'b00;
            r_data_hi <= 8'h00;
            r_word    <= 16'h0000;
            r_timer   <= 8'h00;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_addr_hi <= w_addr_hi_nxt;
            r_count   <= w_count_nxt;
            r_op      <= w_op_nxt;
            r_data_hi <= w_data_hi_nxt;
            r_word    <= w_word_nxt;
            r_timer   <= w_timer_nxt;
            r_armed   <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_addr_nxt         = r_addr;
        w_addr_hi_nxt      = r_addr_hi;
        w_count_nxt        = r_count;
        w_op_nxt           = r_op;
        w_data_hi_nxt      = r_data_hi;
        w_word_nxt         = r_word;
        w_timer_nxt        = r_timer + 8'd1;
        w_advance          = 1'b0;
        tx_data            = 8'h00;
        tx_valid           = 1'b0;
        mem_write_data_ext = 1'b0;
        mem_write_ins      = 1'b0;
        read_en_ext        = 2'b00;
        start              = 1'b0;
        err                = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_timer_nxt = 8'h00;
                if (w_fire) begin
                    if (rx_data[5:0] != 6'd0) begin
                        err = 1'b1;
                    end else begin
                        w_op_nxt    = rx_data[7:6];
                        w_state_nxt = (rx_data[7:6] == c_OP_START) ? S_START : S_ADDR_HI;
                    end
                end
            end
            S_ADDR_HI: if (w_fire) begin
                w_addr_hi_nxt = rx_data;
                w_state_nxt   = S_ADDR_LO;
            end
            S_ADDR_LO: if (w_fire) begin
                w_addr_nxt  = ADDR_W'({r_addr_hi, rx_data});
                w_state_nxt = S_COUNT;
            end
            S_COUNT: if (w_fire) begin
                w_count_nxt = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                w_state_nxt = (r_op == c_OP_RD_DATA) ? S_RD_REQ : S_DATA_HI;
            end
            S_DATA_HI: if (w_fire) begin
                w_data_hi_nxt = rx_data;
                w_state_nxt   = S_DATA_LO;
            end
            S_DATA_LO: if (w_fire) begin
                w_word_nxt  = {r_data_hi, rx_data};
                w_timer_nxt = 8'h00;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_write_ins      = (r_op == c_OP_WR_INS);
                mem_write_data_ext = (r_op == c_OP_WR_DATA);
                if (r_timer == c_HOLD_LAST) begin
                    w_advance = 1'b1;
                end else begin
                    w_state_nxt = S_WR_HOLD;
                end
            end
            S_WR_HOLD: if (r_timer == c_HOLD_LAST) begin
                w_advance = 1'b1;
            end
            S_RD_REQ: begin
                read_en_ext = 2'b10;
                w_timer_nxt = 8'h00;
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: if (r_timer == c_RD_LAST) begin
                w_word_nxt  = dram_in;
                w_state_nxt = S_TX_HI;
            end
            S_TX_HI: begin
                tx_valid = 1'b1;
                tx_data  = r_word[15:8];
                if (tx_ready) begin
                    w_state_nxt = S_TX_LO;
                end
            end
            S_TX_LO: begin
                tx_valid = 1'b1;
                tx_data  = r_word[7:0];
                if (tx_ready) begin
                    w_advance = 1'b1;
                end
            end
            S_START: begin
                start = 1'b1;
                if (r_timer == c_START_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Shared end-of-word step for both write and read bursts.
        if (w_advance) begin
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_count_nxt = r_count - 9'd1;
            if (r_count == 9'd1) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = (r_op == c_OP_RD_DATA) ? S_RD_REQ : S_DATA_HI;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ext_mem_loader: directed self-checking bench for ext_mem_loader.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ext_mem_loader;

    localparam int ADDR_W    = 9;
    localparam int READ_LAT  = 3;
    localparam int WR_HOLD   = 2;
    localparam int START_LEN = 4;
    localparam int MEM_SZ    = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] dram_in;
    logic [15:0] addr_ext;
    logic [15:0] data_in_ext;
    logic [15:0] iram_in_ext;
    logic        mem_write_data_ext;
    logic        mem_write_ins;
    logic [1:0]  read_en_ext;
    logic        start;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    ext_mem_loader #(
        .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .WR_HOLD(WR_HOLD), .START_LEN(START_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .dram_in(dram_in), .addr_ext(addr_ext),
        .data_in_ext(data_in_ext), .iram_in_ext(iram_in_ext),
        .mem_write_data_ext(mem_write_data_ext), .mem_write_ins(mem_write_ins),
        .read_en_ext(read_en_ext), .start(start), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [1:0]  kind;   // 0 = instruction write, 1 = data write
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    wr_t         wr_log[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];
    logic [15:0] exp_rd[$];
    logic [15:0] wbuf[256];
    logic [15:0] mem[MEM_SZ];
    int          rd_cnt, start_runs, last_start_len, err_cycles;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Data memory: words appear on dram_in only during the cycle READ_LAT after the request.
    logic        rd_v[READ_LAT+1];
    logic [15:0] rd_a[READ_LAT+1];
    assign dram_in = rd_v[READ_LAT] ? mem[rd_a[READ_LAT][ADDR_W-1:0]] : 16'hDEAD;

    initial begin : dram_model
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 16'h0000;
        for (int k = 0; k <= READ_LAT; k++) begin rd_v[k] = 1'b0; rd_a[k] = 16'h0; end
        forever begin
            @(negedge clk);
            for (int k = READ_LAT; k > 0; k--) begin rd_v[k] = rd_v[k-1]; rd_a[k] = rd_a[k-1]; end
            rd_v[0] = rst_n && read_en_ext[1];
            rd_a[0] = addr_ext;
            if (rst_n && mem_write_data_ext) mem[addr_ext[ADDR_W-1:0]] = data_in_ext;
        end
    end

    initial begin : compare
        int          hold_left;
        wr_t         hold, got, e;
        logic        stall;
        logic [7:0]  stall_data;
        int          run;
        hold_left = 0; stall = 1'b0; stall_data = 8'h00; run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_left = 0; stall = 1'b0; run = 0;
                continue;
            end
            check("read_en_ins_zero", 32'(read_en_ext[0]), 32'd0);
            check("strobe_conflict", 32'((mem_write_ins && mem_write_data_ext) ||
                  ((mem_write_ins || mem_write_data_ext) && read_en_ext != 2'b00)), 32'd0);
            check("addr_upper_zero", 32'(addr_ext[15:ADDR_W]), 32'd0);

            if (mem_write_ins || mem_write_data_ext) begin
                got.kind = mem_write_data_ext ? 2'd1 : 2'd0;
                got.addr = addr_ext;
                got.data = mem_write_data_ext ? data_in_ext : iram_in_ext;
                wr_log.push_back(got);
                if (exp_wr.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_strobe: got addr 0x%0h data 0x%0h, expected no strobe",
                             got.addr, got.data);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_kind", 32'(got.kind), 32'(e.kind));
                    check("wr_addr", 32'(got.addr), 32'(e.addr));
                    check("wr_data", 32'(got.data), 32'(e.data));
                end
                hold = got;
                hold_left = WR_HOLD - 1;
            end else if (hold_left > 0) begin
                check("hold_addr", 32'(addr_ext), 32'(hold.addr));
                check("hold_data", 32'(hold.kind == 2'd1 ? data_in_ext : iram_in_ext), 32'(hold.data));
                hold_left--;
            end

            if (read_en_ext[1]) begin
                rd_cnt++;
                if (exp_rd.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_read: got addr 0x%0h, expected no read", addr_ext);
                end else begin
                    check("rd_addr", 32'(addr_ext), 32'(exp_rd.pop_front()));
                end
            end

            if (tx_valid) begin
                if (stall) check("tx_stable", 32'(tx_data), 32'(stall_data));
                if (tx_ready) begin
                    tx_log.push_back(tx_data);
                    if (exp_tx.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_tx: got 0x%0h, expected no byte", tx_data);
                    end else begin
                        check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                    end
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    stall_data = tx_data;
                end
            end else begin
                if (stall) check("tx_valid_held", 32'(tx_valid), 32'd1);
                stall = 1'b0;
            end

            if (start) begin
                run++;
                check("busy_in_start", 32'(busy), 32'd1);
            end else if (run > 0) begin
                start_runs++;
                last_start_len = run;
                check("start_len", 32'(run), 32'(START_LEN));
                run = 0;
            end

            if (err) err_cycles++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 1000) begin
            n_checks++; n_fail++;
            $display("FAIL rx_ready_timeout: got rx_ready 0, expected 1 within 1000 cycles");
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [1:0] op, input logic [15:0] base, input int n);
        wr_t e;
        send_byte({op, 6'd0});
        send_byte(base[15:8]);
        send_byte(base[7:0]);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            e.kind = op;
            e.addr = 16'(((int'(base) % MEM_SZ) + i) % MEM_SZ);
            e.data = wbuf[i];
            exp_wr.push_back(e);
            send_byte(wbuf[i][15:8]);
            send_byte(wbuf[i][7:0]);
        end
    endtask

    task automatic do_read(input logic [15:0] base, input int n);
        int a;
        for (int i = 0; i < n; i++) begin
            a = ((int'(base) % MEM_SZ) + i) % MEM_SZ;
            exp_rd.push_back(16'(a));
            exp_tx.push_back(mem[a][15:8]);
            exp_tx.push_back(mem[a][7:0]);
        end
        send_byte(8'h80);
        send_byte(base[15:8]);
        send_byte(base[7:0]);
        send_byte(8'(n));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_tx"}, 32'({tx_valid, tx_data}), 32'd0);
        check({tag, "_addr"}, 32'(addr_ext), 32'd0);
        check({tag, "_wdata"}, {data_in_ext, iram_in_ext}, 32'd0);
        check({tag, "_ctrl"}, 32'({mem_write_data_ext, mem_write_ins, read_en_ext, start, busy, err}), 32'd0);
    endtask

    task automatic clear_logs();
        wr_log.delete(); tx_log.delete();
        rd_cnt = 0; start_runs = 0; last_start_len = 0; err_cycles = 0;
    endtask

    task automatic check_queues_empty(input string tag);
        check({tag, "_wr_pending"}, 32'(exp_wr.size()), 32'd0);
        check({tag, "_tx_pending"}, 32'(exp_tx.size()), 32'd0);
        check({tag, "_rd_pending"}, 32'(exp_rd.size()), 32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int guard;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; rst_n = 1'b0;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_rx_ready", 32'(rx_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Data write, two words
        clear_logs();
        wbuf[0] = 16'hABCD; wbuf[1] = 16'h1234;
        do_write(2'b01, 16'h0010, 2);
        wait_idle();
        check("wd_count", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            check("wd0", {wr_log[0].kind == 2'd1, 15'(wr_log[0].addr), wr_log[0].data}, {1'b1, 15'h0010, 16'hABCD});
            check("wd1", {wr_log[1].kind == 2'd1, 15'(wr_log[1].addr), wr_log[1].data}, {1'b1, 15'h0011, 16'h1234});
        end
        check_queues_empty("wd");

        // Instruction write wrapping across the top of the address space
        clear_logs();
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222;
        do_write(2'b00, 16'h01FF, 2);
        wait_idle();
        check("wi_count", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            check("wi0", {wr_log[0].kind == 2'd0, 15'(wr_log[0].addr), wr_log[0].data}, {1'b1, 15'h01FF, 16'h1111});
            check("wi1", {wr_log[1].kind == 2'd0, 15'(wr_log[1].addr), wr_log[1].data}, {1'b1, 15'h0000, 16'h2222});
        end
        check_queues_empty("wi");

        // Readback with backpressure
        clear_logs();
        mem[16'h020] = 16'hBEEF;
        tx_ready = 1'b0;
        do_read(16'h0020, 1);
        guard = 0;
        while (!tx_valid && guard < 50) begin @(posedge clk); #1; guard++; end
        check("rd_tx_valid_seen", 32'(tx_valid), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_tx", 32'({tx_valid, tx_data}), {23'd0, 1'b1, 8'hBE});
        end
        tx_ready = 1'b1;
        wait_idle();
        check("rd_bytes", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() == 2) check("rd_word", 32'({tx_log[0], tx_log[1]}), 32'h0000BEEF);
        check("rd_req_count", 32'(rd_cnt), 32'd1);
        check_queues_empty("rd");

        // Multi-word readback of the earlier data write
        clear_logs();
        do_read(16'h0010, 2);
        wait_idle();
        check("rd2_bytes", 32'(tx_log.size()), 32'd4);
        if (tx_log.size() == 4) check("rd2_data", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'hABCD1234);
        check_queues_empty("rd2");

        // Start pulse
        clear_logs();
        send_byte(8'hC0);
        wait_idle();
        check("start_runs", 32'(start_runs), 32'd1);
        check("start_len_literal", 32'(last_start_len), 32'd4);

        // Illegal command byte
        clear_logs();
        send_byte(8'h41);
        repeat (2) begin @(posedge clk); #1; end
        check("err_cycles", 32'(err_cycles), 32'd1);
        check("err_no_strobe", 32'(wr_log.size()), 32'd0);
        check("err_stays_idle", 32'({busy, rx_ready}), 32'd1);

        // Count 0 means 256 words
        clear_logs();
        for (int i = 0; i < 256; i++) wbuf[i] = {8'(i), ~8'(i)};
        do_write(2'b01, 16'h0000, 256);
        wait_idle();
        check("c0_count", 32'(wr_log.size()), 32'd256);
        if (wr_log.size() == 256) begin
            check("c0_first", {15'(wr_log[0].addr), wr_log[0].data}, {15'h0000, 16'h00FF});
            check("c0_last", {15'(wr_log[255].addr), wr_log[255].data}, {15'h00FF, 16'hFF00});
        end
        check_queues_empty("c0");

        // Reset in the middle of the second word of a write
        clear_logs();
        wbuf[0] = 16'h5A5A;
        send_byte(8'h40); send_byte(8'h00); send_byte(8'h30); send_byte(8'h02);
        exp_wr.push_back('{kind: 2'd1, addr: 16'h0030, data: 16'h5A5A});
        send_byte(8'h5A); send_byte(8'h5A);
        send_byte(8'h12);
        check("mid_first_written", 32'(wr_log.size()), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        exp_wr.delete(); exp_tx.delete(); exp_rd.delete();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("mid_reset_held");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        send_byte(8'hC0);
        wait_idle();
        check("post_reset_start", 32'(start_runs), 32'd1);
        check("post_reset_no_strobe", 32'(wr_log.size()), 32'd0);
        check_queues_empty("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
